cache_ctrl_2way: RTL and testbench

Parametrised 2-way set-associative, write-back, write-allocate byte cache controller. It sits between the processor-side request port (Ejecute/Lectura_Escritura/Direccion) and the lower memory level, which it reaches through a push FIFO carrying requests and a pop FIFO carrying refills. Line size, set count and address width are parameters. Compared with the direct-mapped generation it adds:
- per-set LRU replacement
- FIFO backpressure
- a busy flag
- refill address checking

---
 rtl/cache_ctrl_2way_if.sv | 35 +++
 rtl/cache_ctrl_2way.sv | 182 ++++++++++++++++++
 tb/tb_cache_ctrl_2way.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_2way_if.sv
// Processor-side request port plus the request/refill FIFO ports of the
// 2-way cache controller, grouped as one bundle.
interface cache_ctrl_2way_if #(
  parameter int ADDR_W     = 24,
  parameter int LINE_BYTES = 8
);
  localparam int LINE_W = 8 * LINE_BYTES;

  logic                     Ejecute;
  logic                     Lectura_Escritura;
  logic [ADDR_W-1:0]        Direccion;
  logic [7:0]               Dato_Entrada;
  logic [7:0]               Dato_Salida;
  logic                     Dato_Listo;
  logic                     Ocupado;
  logic                     Push;
  logic [ADDR_W+LINE_W:0]   D_Push;
  logic                     Lleno;
  logic                     PNDNG;
  logic                     Pop;
  logic [ADDR_W+LINE_W-1:0] D_POP;
  logic                     Error;

  // Controller side
  modport slave (
    input  Ejecute, Lectura_Escritura, Direccion, Dato_Entrada, Lleno, PNDNG, D_POP,
    output Dato_Salida, Dato_Listo, Ocupado, Push, D_Push, Pop, Error
  );

  // Processor / memory-system side
  modport master (
    output Ejecute, Lectura_Escritura, Direccion, Dato_Entrada, Lleno, PNDNG, D_POP,
    input  Dato_Salida, Dato_Listo, Ocupado, Push, D_Push, Pop, Error
  );
endinterface

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative, write-back, write-allocate byte cache controller.
// Misses go out as line requests on a push FIFO; refills return on a
// first-word-fall-through pop FIFO.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | waiting for Ejecute, request latched on acceptance
//   S_LOOKUP    | tag compare; hit completes, miss picks a victim way
//   S_WRITEBACK | pushing the dirty victim line (held while Lleno)
//   S_FETCH     | pushing the line fetch request (held while Lleno)
//   S_WAIT      | waiting for PNDNG, pops and captures the refill
//   S_FILL      | installs the refill in the victim way and applies request
//   S_DONE      | Dato_Listo pulse, back to idle
module cache_ctrl_2way #(
  parameter int ADDR_W     = 24,
  parameter int LINE_BYTES = 8,
  parameter int SETS       = 16
) (
  input logic          CLK,
  input logic          RST,
  cache_ctrl_2way_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_WAIT      = 3'd4;
  localparam logic [2:0] S_FILL      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]        state;
  logic              req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_din;
  logic              victim;
  logic [LINE_W-1:0] fill_data;
  logic [7:0]        dout;
  logic              err;

  logic [1:0]        valid_q [SETS];
  logic [1:0]        dirty_q [SETS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [SETS][2];
  logic [LINE_W-1:0] line_q  [SETS][2];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] line_addr;
  logic [OFF_W+2:0]  bit_off;
  logic [1:0]        set_valid;
  logic [1:0]        set_dirty;
  logic              hit0;
  logic              hit1;
  logic              hit;
  logic              hit_way;
  logic              miss_victim;
  logic              need_wb;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] fill_line;
  logic [ADDR_W+LINE_W:0] d_push;

  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_off   = req_addr[OFF_W-1:0];
  assign line_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
  assign bit_off   = {req_off, 3'b000};

  assign set_valid = valid_q[req_idx];
  assign set_dirty = dirty_q[req_idx];
  assign hit0      = set_valid[0] && (tag_q[req_idx][0] == req_tag);
  assign hit1      = set_valid[1] && (tag_q[req_idx][1] == req_tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = ~hit0;
  assign hit_line  = line_q[req_idx][hit_way];

  // Empty ways are filled before anything gets evicted; way 0 goes first.
  assign miss_victim = !set_valid[0] ? 1'b0 :
                       !set_valid[1] ? 1'b1 : lru_q[req_idx];
  assign need_wb     = set_valid[miss_victim] && set_dirty[miss_victim];

  // Refilled line with the pending write byte merged in
  always_comb begin
    fill_line = fill_data;
    if (!req_rd) fill_line[bit_off +: 8] = req_din;
  end

  // Outgoing FIFO word: dirty victim line, or a data-less fetch of the request line
  always_comb begin
    d_push = '0;
    if (state == S_WRITEBACK)
      d_push = {1'b0, tag_q[req_idx][victim], req_idx, {OFF_W{1'b0}}, line_q[req_idx][victim]};
    else if (state == S_FETCH)
      d_push = {1'b1, line_addr, {LINE_W{1'b0}}};
  end

  assign bus.D_Push      = d_push;
  assign bus.Push        = ((state == S_WRITEBACK) || (state == S_FETCH)) && !bus.Lleno;
  assign bus.Pop         = (state == S_WAIT) && bus.PNDNG;
  assign bus.Ocupado     = (state != S_IDLE);
  assign bus.Dato_Listo  = (state == S_DONE);
  assign bus.Dato_Salida = dout;
  assign bus.Error       = err;

  // Sequencing, request latch, status bits and output data register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      req_rd    <= 1'b0;
      req_addr  <= '0;
      req_din   <= '0;
      victim    <= 1'b0;
      fill_data <= '0;
      dout      <= '0;
      err       <= 1'b0;
      lru_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Ejecute) begin
            req_rd   <= bus.Lectura_Escritura;
            req_addr <= bus.Direccion;
            req_din  <= bus.Dato_Entrada;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (req_rd) begin
              dout <= hit_line[bit_off +: 8];
            end else begin
              dout <= req_din;
              dirty_q[req_idx][hit_way] <= 1'b1;
            end
            lru_q[req_idx] <= ~hit_way;
            state <= S_DONE;
          end else begin
            victim <= miss_victim;
            state  <= need_wb ? S_WRITEBACK : S_FETCH;
          end
        end
        S_WRITEBACK: if (!bus.Lleno) state <= S_FETCH;
        S_FETCH:     if (!bus.Lleno) state <= S_WAIT;
        S_WAIT: begin
          if (bus.PNDNG) begin
            fill_data <= bus.D_POP[LINE_W-1:0];
            if (bus.D_POP[ADDR_W+LINE_W-1 -: ADDR_W] != line_addr) err <= 1'b1;
            state <= S_FILL;
          end
        end
        S_FILL: begin
          valid_q[req_idx][victim] <= 1'b1;
          dirty_q[req_idx][victim] <= ~req_rd;
          lru_q[req_idx]           <= ~victim;
          dout                     <= fill_line[bit_off +: 8];
          state                    <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line data and tags: no reset needed, valid bits qualify them
  always_ff @(posedge CLK) begin
    if ((state == S_LOOKUP) && hit && !req_rd)
      line_q[req_idx][hit_way][bit_off +: 8] <= req_din;
    if (state == S_FILL) begin
      line_q[req_idx][victim] <= fill_line;
      tag_q[req_idx][victim]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Bench for cache_ctrl_2way: a transaction-level cache/memory model drives
// per-cycle expectations; directed requests pin the model with literals,
// then randomized traffic with FIFO backpressure runs against it.
module tb_cache_ctrl_2way;
  localparam int AW = 24;
  localparam int LB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_ctrl_2way_if #(.ADDR_W(AW), .LINE_BYTES(LB)) bus ();
  cache_ctrl_2way #(.ADDR_W(AW), .LINE_BYTES(LB), .SETS(16)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // cache model
  bit          mv   [16][2];
  bit          md   [16][2];
  logic [16:0] mt   [16][2];
  logic [63:0] mdat [16][2];
  bit          mlru [16];
  logic [63:0] mem [logic [23:0]];
  bit          seed_en;
  logic [88:0] pushq [$];
  logic [87:0] rfq [$];

  // transaction progress
  bit m_busy, m_look, m_hit, m_wait, m_fill, m_done, m_err, m_vic;
  logic [7:0] m_dout, pend_dout;
  bit r_rd; logic [23:0] r_addr; logic [7:0] r_din;

  // stimulus knobs
  bit want_req, q_rd; logic [23:0] q_addr; logic [7:0] q_din;
  bit noise_en, corrupt_next;
  int lleno_mode, pndng_mode, win_lo, win_hi;

  // observations
  int lat, last_lat, req_pushes;
  logic [88:0] first_push, last_push;
  logic [7:0] seen_dout;

  function automatic logic [63:0] mem_read(input logic [23:0] a);
    if (!mem.exists(a)) mem[a] = seed_en ? {$urandom, $urandom} : 64'h0;
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      mv[s][0] = 0; mv[s][1] = 0; md[s][0] = 0; md[s][1] = 0; mlru[s] = 0;
    end
    pushq.delete(); rfq.delete();
    m_busy = 0; m_look = 0; m_hit = 0; m_wait = 0; m_fill = 0; m_done = 0; m_err = 0;
    m_dout = 8'h00; pend_dout = 8'h00; lat = 0;
  endtask

  task automatic accept();
    logic [16:0] tg;
    int ix, of, hw;
    tg = r_addr[23:7]; ix = int'(r_addr[6:3]); of = int'(r_addr[2:0]); hw = -1;
    for (int w = 0; w < 2; w++)
      if (hw < 0 && mv[ix][w] && mt[ix][w] == tg) hw = w;
    if (hw >= 0) begin
      m_hit = 1;
      if (r_rd) pend_dout = mdat[ix][hw][of*8 +: 8];
      else begin
        mdat[ix][hw][of*8 +: 8] = r_din; md[ix][hw] = 1; pend_dout = r_din;
      end
      mlru[ix] = (hw == 0);
    end else begin
      m_hit = 0;
      m_vic = !mv[ix][0] ? 1'b0 : (!mv[ix][1] ? 1'b1 : mlru[ix]);
      if (mv[ix][m_vic] && md[ix][m_vic])
        pushq.push_back({1'b0, mt[ix][m_vic], 4'(ix), 3'b000, mdat[ix][m_vic]});
      pushq.push_back({1'b1, tg, 4'(ix), 3'b000, 64'h0});
    end
  endtask

  task automatic install(input logic [87:0] e);
    int ix, of;
    logic [63:0] d;
    ix = int'(r_addr[6:3]); of = int'(r_addr[2:0]); d = e[63:0];
    if (e[87:64] !== {r_addr[23:3], 3'b000}) m_err = 1;
    if (!r_rd) d[of*8 +: 8] = r_din;
    mv[ix][m_vic] = 1; md[ix][m_vic] = !r_rd; mt[ix][m_vic] = r_addr[23:7];
    mdat[ix][m_vic] = d; mlru[ix] = !m_vic; pend_dout = d[of*8 +: 8];
  endtask

  task automatic drive();
    bus.Ejecute = 0;
    if (!m_busy && want_req) begin
      bus.Ejecute = 1; bus.Lectura_Escritura = q_rd; bus.Direccion = q_addr; bus.Dato_Entrada = q_din;
      want_req = 0;
    end else if (m_busy && !m_done && noise_en && $urandom_range(0, 2) == 0) begin
      bus.Ejecute = 1; bus.Lectura_Escritura = 1'($urandom);
      bus.Direccion = 24'($urandom); bus.Dato_Entrada = 8'($urandom);
    end
    case (lleno_mode)
      1:       bus.Lleno = ($urandom_range(0, 9) < 3);
      2:       bus.Lleno = m_busy && (lat + 1 >= win_lo) && (lat + 1 <= win_hi);
      default: bus.Lleno = 0;
    endcase
    bus.PNDNG = (rfq.size() > 0) &&
                ((pndng_mode == 0) || ((pndng_mode == 1) && ($urandom_range(0, 9) < 6)));
    bus.D_POP = (rfq.size() > 0) ? rfq[0] : 88'h0;
  endtask

  // One compare point per cycle, then advance the model over the coming edge
  task automatic compare_and_advance();
    bit e_push, e_pop;
    logic [88:0] p;
    logic [87:0] e;
    if (m_busy) lat++;
    e_push = m_busy && !m_look && (pushq.size() > 0) && !bus.Lleno;
    e_pop  = m_busy && !m_look && (pushq.size() == 0) && m_wait && bus.PNDNG;
    chk("ocupado", bus.Ocupado, m_busy);
    chk("dato_listo", bus.Dato_Listo, m_done);
    chk("push", bus.Push, e_push);
    chk("pop", bus.Pop, e_pop);
    chk("dato_salida", bus.Dato_Salida, m_dout);
    chk("error", bus.Error, m_err);
    if (e_push) chk("d_push", bus.D_Push, pushq[0]);
    if (bus.Push) begin
      if (req_pushes == 0) first_push = bus.D_Push;
      last_push = bus.D_Push; req_pushes++;
    end
    if (bus.Dato_Listo) begin last_lat = lat; seen_dout = bus.Dato_Salida; end

    if (!m_busy) begin
      if (bus.Ejecute) begin
        r_rd = bus.Lectura_Escritura; r_addr = bus.Direccion; r_din = bus.Dato_Entrada;
        accept(); m_busy = 1; m_look = 1; lat = 0; req_pushes = 0;
      end
    end else if (m_look) begin
      m_look = 0;
      if (m_hit) begin m_dout = pend_dout; m_done = 1; end
      else m_wait = 1;
    end else if (pushq.size() > 0) begin
      if (!bus.Lleno) begin
        p = pushq.pop_front();
        if (p[88]) begin
          rfq.push_back({corrupt_next ? (p[87:64] ^ 24'h000100) : p[87:64], mem_read(p[87:64])});
          corrupt_next = 0;
        end else mem[p[87:64]] = p[63:0];
      end
    end else if (m_wait) begin
      if (bus.PNDNG) begin e = rfq.pop_front(); install(e); m_wait = 0; m_fill = 1; end
    end else if (m_fill) begin
      m_fill = 0; m_done = 1; m_dout = pend_dout;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1 drive();
    #4 compare_and_advance();
  endtask

  task automatic do_req(input bit rd, input logic [23:0] a, input logic [7:0] d);
    int b;
    q_rd = rd; q_addr = a; q_din = d; want_req = 1;
    cycle();
    b = 0;
    while (m_busy && b < 400) begin cycle(); b++; end
    if (m_busy) begin
      checks++; failures++;
      $display("FAIL req_timeout: request %0h still busy after %0d cycles", a, b);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n;
    logic [16:0] tags [3];
    tags[0] = 17'h00000; tags[1] = 17'h00001; tags[2] = 17'h15a5a;
    bus.Ejecute = 0; bus.Lectura_Escritura = 0; bus.Direccion = '0; bus.Dato_Entrada = '0;
    bus.Lleno = 0; bus.PNDNG = 0; bus.D_POP = '0;
    seed_en = 0; want_req = 0; noise_en = 0; corrupt_next = 0;
    lleno_mode = 0; pndng_mode = 0; win_lo = 0; win_hi = 0;
    last_lat = 0; req_pushes = 0; first_push = '0; last_push = '0; seen_dout = '0;
    model_reset();
    mem[24'hfffff8] = 64'haa00_0000_0000_0000;

    #12;
    chk("rst_ocupado", bus.Ocupado, 1'b0);
    chk("rst_listo", bus.Dato_Listo, 1'b0);
    chk("rst_push", bus.Push, 1'b0);
    chk("rst_pop", bus.Pop, 1'b0);
    chk("rst_dout", bus.Dato_Salida, 8'h00);
    chk("rst_error", bus.Error, 1'b0);
    @(negedge clk) rst = 0;

    do_req(0, 24'h000000, 8'hff);
    chk("fill_lat", last_lat, 5);
    chk("fill_dout", seen_dout, 8'hff);
    chk("fill_npush", req_pushes, 1);
    chk("fill_fetch", last_push, {1'b1, 24'h000000, 64'h0});
    do_req(0, 24'h000001, 8'haa); chk("hit_lat_a", last_lat, 2); chk("hit_npush_a", req_pushes, 0);
    do_req(0, 24'h000002, 8'hbb); chk("hit_lat_b", last_lat, 2); chk("hit_npush_b", req_pushes, 0);
    do_req(0, 24'h000003, 8'hcc); chk("hit_lat_c", last_lat, 2); chk("hit_npush_c", req_pushes, 0);
    do_req(1, 24'h000001, 8'h00); chk("rd_hit_lat", last_lat, 2); chk("rd_hit_dout", seen_dout, 8'haa);

    do_req(0, 24'h000080, 8'h33); chk("way1_lat", last_lat, 5);
    do_req(0, 24'h000100, 8'h44);
    chk("evict_lat", last_lat, 6);
    chk("evict_npush", req_pushes, 2);
    chk("evict_wb", first_push, {1'b0, 24'h000000, 64'h00000000_ccbbaaff});
    chk("evict_fetch", last_push, {1'b1, 24'h000100, 64'h0});

    do_req(1, 24'hffffff, 8'h00);
    chk("set15_lat", last_lat, 5);
    chk("set15_npush", req_pushes, 1);
    chk("set15_dout", seen_dout, 8'haa);

    lleno_mode = 2; win_lo = 2; win_hi = 4; noise_en = 1;
    do_req(1, 24'h000008, 8'h00);
    chk("lleno_lat", last_lat, 8);
    chk("lleno_npush", req_pushes, 1);
    lleno_mode = 0; noise_en = 0;

    corrupt_next = 1;
    do_req(1, 24'h000010, 8'h00);
    chk("bad_refill_lat", last_lat, 5);
    chk("bad_refill_err", bus.Error, 1'b1);
    do_req(1, 24'h000008, 8'h00);
    chk("err_sticky_lat", last_lat, 2);
    chk("err_sticky", bus.Error, 1'b1);

    pndng_mode = 2;
    q_rd = 1; q_addr = 24'h000018; q_din = 8'h00; want_req = 1;
    n = 0;
    do begin cycle(); n++; end while (!(m_busy && m_wait && pushq.size() == 0) && n < 20);
    chk("reached_wait", {m_wait, 1'b0}, 2'b10);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_ocupado", bus.Ocupado, 1'b0);
    chk("midrst_listo", bus.Dato_Listo, 1'b0);
    chk("midrst_push", bus.Push, 1'b0);
    chk("midrst_pop", bus.Pop, 1'b0);
    chk("midrst_dout", bus.Dato_Salida, 8'h00);
    chk("midrst_error", bus.Error, 1'b0);
    model_reset();
    @(negedge clk) rst = 0;
    pndng_mode = 0;
    do_req(1, 24'h000001, 8'h00);
    chk("post_rst_lat", last_lat, 5);
    chk("post_rst_npush", req_pushes, 1);
    chk("post_rst_dout", seen_dout, 8'haa);

    seed_en = 1; lleno_mode = 1; pndng_mode = 1; noise_en = 1;
    for (int i = 0; i < 400; i++) begin
      corrupt_next = ($urandom_range(0, 15) == 0);
      do_req(1'($urandom), {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 3)), 3'($urandom)},
             8'($urandom));
      if ($urandom_range(0, 3) == 0) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
